// File: rtl/stream_comp_scheduler.sv
// Canonical-scheduler controller for the stream computation actor: checks the
// current mode's enable condition, pulses invoke, waits for FC, tracks the next mode.
module stream_comp_scheduler #(
  parameter int width     = 10,
  parameter int pop_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [pop_width-1:0] pop_data,
  input  logic [pop_width-1:0] pop_length,
  input  logic [pop_width-1:0] pop_command,
  input  logic [pop_width-1:0] free_out,
  input  logic [width-1:0]     length_head,
  input  logic                 FC,
  input  logic [1:0]           next_mode_out,
  output logic                 invoke,
  output logic [1:0]           next_mode_in,
  output logic                 stall,
  output logic                 mode_err,
  output logic [15:0]          firing_count
);

  localparam int cmp_width = (width > pop_width) ? width : pop_width;

  localparam logic [1:0] MODE_SETUP  = 2'b00;
  localparam logic [1:0] MODE_COMP   = 2'b01;
  localparam logic [1:0] MODE_OUTPUT = 2'b10;
  localparam logic [1:0] MODE_BAD    = 2'b11;

  typedef enum logic [1:0] {IDLE, ENABLE, INVOKE, WAIT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           cur_mode_q, cur_mode_d;
  logic [width-1:0]     l_reg_q, l_reg_d;
  logic                 mode_err_q, mode_err_d;
  logic [15:0]          firing_count_q, firing_count_d;
  logic                 enabled;
  logic [cmp_width-1:0] pop_data_ext, l_reg_ext;

  assign pop_data_ext = cmp_width'(pop_data);
  assign l_reg_ext    = cmp_width'(l_reg_q);

  // A zero vector length compares as always enabled, so COMP never blocks on it.
  always_comb begin
    enabled = 1'b0;
    case (cur_mode_q)
      MODE_SETUP:  enabled = (pop_length != '0) && (pop_command != '0);
      MODE_COMP:   enabled = (pop_data_ext >= l_reg_ext);
      MODE_OUTPUT: enabled = (free_out != '0);
      default:     enabled = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cur_mode_d     = cur_mode_q;
    l_reg_d        = l_reg_q;
    mode_err_d     = mode_err_q;
    firing_count_d = firing_count_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = ENABLE;
      end
      ENABLE: begin
        if (!run)        state_d = IDLE;
        else if (enabled) state_d = INVOKE;
      end
      INVOKE: begin
        if (cur_mode_q == MODE_SETUP) l_reg_d = length_head;
        state_d = WAIT;
      end
      WAIT: begin
        // A firing in flight is never abandoned; run only matters once FC arrives.
        if (FC) begin
          firing_count_d = firing_count_q + 16'd1;
          if (next_mode_out == MODE_BAD) begin
            cur_mode_d = MODE_SETUP;
            mode_err_d = 1'b1;
          end else begin
            cur_mode_d = next_mode_out;
          end
          state_d = run ? ENABLE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      cur_mode_q     <= MODE_SETUP;
      l_reg_q        <= '0;
      mode_err_q     <= 1'b0;
      firing_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cur_mode_q     <= cur_mode_d;
      l_reg_q        <= l_reg_d;
      mode_err_q     <= mode_err_d;
      firing_count_q <= firing_count_d;
    end
  end

  assign invoke       = (state_q == INVOKE);
  assign next_mode_in = cur_mode_q;
  assign stall        = (state_q == ENABLE) && run && !enabled;
  assign mode_err     = mode_err_q;
  assign firing_count = firing_count_q;

endmodule

// File: tb/tb_stream_comp_scheduler.sv
// Scoreboard bench for stream_comp_scheduler: expected invoke modes are queued as
// stimulus is set up and popped whenever the scheduler pulses invoke.
module tb_stream_comp_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  pop_data, pop_length, pop_command, free_out;
  logic [9:0]  length_head;
  logic        FC;
  logic [1:0]  next_mode_out;
  logic        invoke;
  logic [1:0]  next_mode_in;
  logic        stall;
  logic        mode_err;
  logic [15:0] firing_count;

  int         total_checks = 0;
  int         bad_checks   = 0;
  int         exp_count    = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_mode;

  stream_comp_scheduler #(.width(10), .pop_width(8)) dut (
    .clk(clk), .rst(rst), .run(run),
    .pop_data(pop_data), .pop_length(pop_length), .pop_command(pop_command),
    .free_out(free_out), .length_head(length_head),
    .FC(FC), .next_mode_out(next_mode_out),
    .invoke(invoke), .next_mode_in(next_mode_in), .stall(stall),
    .mode_err(mode_err), .firing_count(firing_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every invoke must match the next queued mode; an invoke with nothing queued is an error.
  always @(negedge clk) begin
    if (invoke === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_invoke", 32'd1, 32'd0);
      end else begin
        mon_mode = exp_q.pop_front();
        checkOutput("invoke_mode", {30'd0, next_mode_in}, {30'd0, mon_mode});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] pd, input logic [7:0] pl,
                               input logic [7:0] pc, input logic [7:0] fo, input logic [9:0] lh);
    run         = r;
    pop_data    = pd;
    pop_length  = pl;
    pop_command = pc;
    free_out    = fo;
    length_head = lh;
  endtask

  task automatic waitInvoke(input int max_cycles);
    int n = 0;
    while (invoke !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    if (invoke !== 1'b1) checkOutput("invoke_timeout", 32'd0, 32'd1);
  endtask

  // Stub actor: called in the invoke cycle, raises FC for one cycle 'delay' cycles later.
  task automatic fireActor(input int delay, input logic [1:0] mode);
    repeat (delay) tick();
    FC            = 1'b1;
    next_mode_out = mode;
    tick();
    FC            = 1'b0;
    next_mode_out = 2'b00;
    exp_count++;
    checkOutput("firing_count", {16'd0, firing_count}, exp_count);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 0 expected 1");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst           = 1'b0;
    FC            = 1'b0;
    next_mode_out = 2'b00;
    applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 10'd0);
    tick();
    tick();
    checkOutput("rst_invoke", {31'd0, invoke}, 32'd0);
    checkOutput("rst_mode", {30'd0, next_mode_in}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_mode_err", {31'd0, mode_err}, 32'd0);
    checkOutput("rst_count", {16'd0, firing_count}, 32'd0);

    // Basic mode sequence with back-to-back firings
    rst = 1'b1;
    applyStimulus(1'b1, 8'd3, 8'd1, 8'd1, 8'd4, 10'd3);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    tick();
    checkOutput("c1_no_invoke", {31'd0, invoke}, 32'd0);
    tick();
    checkOutput("c2_invoke", {31'd0, invoke}, 32'd1);
    fireActor(4, 2'b01);
    tick();
    checkOutput("comp_invoke_k2", {31'd0, invoke}, 32'd1);
    fireActor(4, 2'b10);
    tick();
    checkOutput("out_invoke_k2", {31'd0, invoke}, 32'd1);
    fireActor(4, 2'b00);
    run = 1'b0;
    tick();
    tick();
    checkOutput("basic_mode_back", {30'd0, next_mode_in}, 32'd0);

    // COMP stall until pop_data reaches the latched length
    applyStimulus(1'b1, 8'd4, 8'd1, 8'd1, 8'd4, 10'd5);
    exp_q.push_back(2'b00);
    waitInvoke(5);
    fireActor(3, 2'b01);
    for (int i = 0; i < 3; i++) begin
      checkOutput("comp_stall", {31'd0, stall}, 32'd1);
      checkOutput("comp_no_invoke", {31'd0, invoke}, 32'd0);
      tick();
    end
    pop_data = 8'd5;
    exp_q.push_back(2'b01);
    tick();
    checkOutput("comp_release_invoke", {31'd0, invoke}, 32'd1);
    checkOutput("comp_release_stall", {31'd0, stall}, 32'd0);

    // Run dropped during WAIT: firing still completes, then idle
    tick();
    run = 1'b0;
    fireActor(3, 2'b10);
    checkOutput("drop_mode", {30'd0, next_mode_in}, 32'd2);
    repeat (5) tick();
    checkOutput("drop_idle_stall", {31'd0, stall}, 32'd0);
    checkOutput("drop_idle_invoke", {31'd0, invoke}, 32'd0);

    // Invalid mode returned by the actor
    run = 1'b1;
    exp_q.push_back(2'b10);
    waitInvoke(5);
    fireActor(2, 2'b11);
    checkOutput("bad_mode_err", {31'd0, mode_err}, 32'd1);
    checkOutput("bad_mode_fallback", {30'd0, next_mode_in}, 32'd0);
    length_head = 10'd7;
    exp_q.push_back(2'b00);
    tick();
    checkOutput("bad_next_invoke", {31'd0, invoke}, 32'd1);
    fireActor(2, 2'b01);
    checkOutput("mode_err_sticky", {31'd0, mode_err}, 32'd1);
    checkOutput("len7_stall", {31'd0, stall}, 32'd1);

    // FC while in ENABLE is ignored
    FC            = 1'b1;
    next_mode_out = 2'b10;
    tick();
    FC            = 1'b0;
    next_mode_out = 2'b00;
    checkOutput("spurious_count", {16'd0, firing_count}, exp_count);
    checkOutput("spurious_mode", {30'd0, next_mode_in}, 32'd1);
    checkOutput("spurious_stall", {31'd0, stall}, 32'd1);

    // Reset in the middle of a firing
    pop_data = 8'd7;
    exp_q.push_back(2'b01);
    tick();
    checkOutput("pre_rst_invoke", {31'd0, invoke}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    exp_count = 0;
    checkOutput("mid_rst_invoke", {31'd0, invoke}, 32'd0);
    checkOutput("mid_rst_mode", {30'd0, next_mode_in}, 32'd0);
    checkOutput("mid_rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("mid_rst_mode_err", {31'd0, mode_err}, 32'd0);
    checkOutput("mid_rst_count", {16'd0, firing_count}, 32'd0);

    // Zero length after reset release: no COMP stall, k+2 invoke spacing
    rst = 1'b1;
    applyStimulus(1'b1, 8'd0, 8'd1, 8'd1, 8'd4, 10'd0);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    tick();
    checkOutput("post_rst_c1", {31'd0, invoke}, 32'd0);
    tick();
    checkOutput("post_rst_c2", {31'd0, invoke}, 32'd1);
    fireActor(4, 2'b01);
    checkOutput("zero_len_no_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("zero_len_invoke_k2", {31'd0, invoke}, 32'd1);
    tick();
    run = 1'b0;
    fireActor(0, 2'b00);
    repeat (4) tick();
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
